// File: rtl/div_pkg.sv
// Shared definitions for the divider issue controller: FSM encoding and default constants.
package div_pkg;

    localparam int unsigned DIV_LATENCY = 32;
    localparam logic [31:0] DIVZERO_RES = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_issue_ctrl.sv
// Issue-queue to divider sequencer: launches one divide, counts its fixed latency,
// holds the result for the CDB, short-circuits divide-by-zero and handles flush.
module div_issue_ctrl
    import div_pkg::*;
#(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       TAG_W       = 6,
    parameter int unsigned       LATENCY     = DIV_LATENCY,
    parameter logic [DATA_W-1:0] DIVZERO_RES = DATA_W'(div_pkg::DIVZERO_RES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [DATA_W-1:0] issue_rsdata,
    input  logic [DATA_W-1:0] issue_rtdata,
    input  logic [TAG_W-1:0]  issue_rdtag,
    output logic              div_enable,
    output logic [DATA_W-1:0] div_rsdata,
    output logic [DATA_W-1:0] div_rtdata,
    output logic [TAG_W-1:0]  div_rdtag,
    input  logic [DATA_W-1:0] div_result,
    input  logic [TAG_W-1:0]  div_tag_in,
    input  logic              flush,
    output logic              cdb_req,
    input  logic              cdb_grant,
    output logic [DATA_W-1:0] cdb_data,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic              cdb_divzero,
    output logic              busy
);

    localparam int unsigned      CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              divzero_q, divzero_d;

    logic ready_c;
    logic accept_c;
    logic rt_zero_c;
    logic cnt_zero_c;
    logic capture_c;

    // Ready is combinational on flush/grant so a granted result can be replaced without a bubble.
    assign ready_c    = !reset && !flush &&
                        ((state_q == ST_IDLE) || ((state_q == ST_DONE) && cdb_grant));
    assign accept_c   = issue_valid && ready_c;
    assign rt_zero_c  = (issue_rtdata == '0);
    assign cnt_zero_c = (cnt_q == '0);
    assign capture_c  = (state_q == ST_WAIT) && cnt_zero_c && !flush;

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            tag_q     <= '0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            tag_q     <= tag_d;
            divzero_q <= divzero_d;
            if (capture_c) begin
                assert (div_tag_in == tag_q)
                else $error("div_issue_ctrl: divider returned tag %0h, latched tag %0h", div_tag_in, tag_q);
            end
        end
    end

    // Next-state: flush dominates, except that a WAIT divide must drain to completion.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        tag_d     = tag_q;
        divzero_d = divzero_q;

        if ((state_q == ST_WAIT) || (state_q == ST_DRAIN)) begin
            cnt_d = cnt_zero_c ? '0 : cnt_q - CNT_W'(1);
        end

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (accept_c) begin
                    tag_d = issue_rdtag;
                    if (rt_zero_c) begin
                        state_d   = ST_DONE;
                        data_d    = DIVZERO_RES;
                        divzero_d = 1'b1;
                    end else begin
                        state_d   = ST_WAIT;
                        cnt_d     = CNT_LOAD;
                        divzero_d = 1'b0;
                    end
                end else if ((state_q == ST_DONE) && cdb_grant) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_zero_c) begin
                    if (flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_DONE;
                        data_d    = div_result;
                        divzero_d = 1'b0;
                    end
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cnt_zero_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: launch pulse passes operands through; CDB fields are only driven in DONE.
    always_comb begin
        issue_ready = 1'b0;
        div_enable  = 1'b0;
        div_rsdata  = '0;
        div_rtdata  = '0;
        div_rdtag   = '0;
        cdb_req     = 1'b0;
        cdb_data    = '0;
        cdb_tag     = '0;
        cdb_divzero = 1'b0;
        busy        = 1'b0;

        issue_ready = ready_c;
        if (accept_c && !rt_zero_c) begin
            div_enable = 1'b1;
            div_rsdata = issue_rsdata;
            div_rtdata = issue_rtdata;
            div_rdtag  = issue_rdtag;
        end
        if (state_q == ST_DONE) begin
            cdb_req     = 1'b1;
            cdb_data    = data_q;
            cdb_tag     = tag_q;
            cdb_divzero = divzero_q;
        end
        busy = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a fixed-latency divider model and a CDB scoreboard.
module tb_div_issue_ctrl;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 6;
    localparam int unsigned LAT    = 32;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic              dz;
    } exp_t;

    logic              clk;
    logic              reset;
    logic              issue_valid;
    logic              issue_ready;
    logic [DATA_W-1:0] issue_rsdata;
    logic [DATA_W-1:0] issue_rtdata;
    logic [TAG_W-1:0]  issue_rdtag;
    logic              div_enable;
    logic [DATA_W-1:0] div_rsdata;
    logic [DATA_W-1:0] div_rtdata;
    logic [TAG_W-1:0]  div_rdtag;
    logic [DATA_W-1:0] div_result;
    logic [TAG_W-1:0]  div_tag_in;
    logic              flush;
    logic              cdb_req;
    logic              cdb_grant;
    logic [DATA_W-1:0] cdb_data;
    logic [TAG_W-1:0]  cdb_tag;
    logic              cdb_divzero;
    logic              busy;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    logic [DATA_W-1:0] pipe_data [LAT];
    logic [TAG_W-1:0]  pipe_tag  [LAT];

    div_issue_ctrl #(
        .DATA_W  (DATA_W),
        .TAG_W   (TAG_W),
        .LATENCY (LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_rsdata (issue_rsdata),
        .issue_rtdata (issue_rtdata),
        .issue_rdtag  (issue_rdtag),
        .div_enable   (div_enable),
        .div_rsdata   (div_rsdata),
        .div_rtdata   (div_rtdata),
        .div_rdtag    (div_rdtag),
        .div_result   (div_result),
        .div_tag_in   (div_tag_in),
        .flush        (flush),
        .cdb_req      (cdb_req),
        .cdb_grant    (cdb_grant),
        .cdb_data     (cdb_data),
        .cdb_tag      (cdb_tag),
        .cdb_divzero  (cdb_divzero),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider model: quotient appears LAT cycles after the launch cycle; it is never reset.
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) begin
            pipe_data[i] <= pipe_data[i-1];
            pipe_tag[i]  <= pipe_tag[i-1];
        end
        pipe_data[0] <= (div_enable && div_rtdata != '0) ? div_rsdata / div_rtdata : '0;
        pipe_tag[0]  <= div_enable ? div_rdtag : '0;
    end
    assign div_result = pipe_data[LAT-1];
    assign div_tag_in = pipe_tag[LAT-1];

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Scoreboard: every CDB transfer must match the oldest expected result.
    always @(negedge clk) begin
        #3;
        if (!reset && cdb_req && cdb_grant) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'(sb.size()), 64'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_data", 64'(cdb_data), 64'(e.data));
                check("sb_tag", 64'(cdb_tag), 64'(e.tag));
                check("sb_divzero", 64'(cdb_divzero), 64'(e.dz));
            end
        end
    end

    task automatic wait_req(input int max_cyc, output int lat);
        lat = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk); #1;
            if (cdb_req) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic drive_issue(input logic [DATA_W-1:0] rs, input logic [DATA_W-1:0] rt,
                               input logic [TAG_W-1:0] tag);
        issue_valid  = 1'b1;
        issue_rsdata = rs;
        issue_rtdata = rt;
        issue_rdtag  = tag;
    endtask

    task automatic grant_one();
        @(negedge clk);
        cdb_grant = 1'b1;
        @(posedge clk); #1;
        cdb_grant = 1'b0;
        @(negedge clk); #1;
        check("post_grant_req", 64'(cdb_req), 64'd0);
        check("post_grant_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        int  lat;
        bit  seen;
        exp_t e;

        reset        = 1'b1;
        issue_valid  = 1'b0;
        issue_rsdata = '0;
        issue_rtdata = '0;
        issue_rdtag  = '0;
        flush        = 1'b0;
        cdb_grant    = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            pipe_data[i] = '0;
            pipe_tag[i]  = '0;
        end

        // Reset state
        #1;
        check("rst_ready", 64'(issue_ready), 64'd0);
        check("rst_req", 64'(cdb_req), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cdb_data", 64'(cdb_data), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_ready_after", 64'(issue_ready), 64'd1);

        // 1: basic divide 100/7 tag 5
        @(negedge clk);
        drive_issue(32'd100, 32'd7, 6'd5);
        #1;
        check("t1_enable", 64'(div_enable), 64'd1);
        check("t1_rs", 64'(div_rsdata), 64'd100);
        check("t1_rt", 64'(div_rtdata), 64'd7);
        check("t1_tag", 64'(div_rdtag), 64'd5);
        e = '{data: 32'd14, tag: 6'd5, dz: 1'b0};
        sb.push_back(e);
        @(posedge clk); #1;
        issue_valid = 1'b0;
        @(negedge clk); #1;
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_ready_wait", 64'(issue_ready), 64'd0);
        check("t1_enable_pulse", 64'(div_enable), 64'd0);
        wait_req(60, lat);
        check("t1_latency", 64'(lat + 1), 64'(LAT + 1));
        check("t1_cdb_data", 64'(cdb_data), 64'd14);
        check("t1_cdb_tag", 64'(cdb_tag), 64'd5);
        grant_one();

        // 2: divide by zero 9/0 tag 3
        @(negedge clk);
        drive_issue(32'd9, 32'd0, 6'd3);
        #1;
        check("t2_ready", 64'(issue_ready), 64'd1);
        check("t2_no_enable", 64'(div_enable), 64'd0);
        e = '{data: 32'hFFFF_FFFF, tag: 6'd3, dz: 1'b1};
        sb.push_back(e);
        @(posedge clk); #1;
        issue_valid = 1'b0;
        @(negedge clk); #1;
        check("t2_req", 64'(cdb_req), 64'd1);
        check("t2_data", 64'(cdb_data), 64'hFFFF_FFFF);
        check("t2_divzero", 64'(cdb_divzero), 64'd1);
        check("t2_tag", 64'(cdb_tag), 64'd3);
        grant_one();

        // 3: back-to-back, grant held off 5 cycles then granted with a new issue
        @(negedge clk);
        drive_issue(32'd50, 32'd5, 6'd7);
        e = '{data: 32'd10, tag: 6'd7, dz: 1'b0};
        sb.push_back(e);
        @(posedge clk); #1;
        issue_valid = 1'b0;
        wait_req(60, lat);
        check("t3_latency", 64'(lat), 64'(LAT + 1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("t3_hold_req", 64'(cdb_req), 64'd1);
            check("t3_hold_data", 64'(cdb_data), 64'd10);
            check("t3_hold_ready", 64'(issue_ready), 64'd0);
        end
        @(negedge clk);
        cdb_grant = 1'b1;
        drive_issue(32'd81, 32'd9, 6'd9);
        #1;
        check("t3_b2b_ready", 64'(issue_ready), 64'd1);
        check("t3_b2b_enable", 64'(div_enable), 64'd1);
        check("t3_b2b_rs", 64'(div_rsdata), 64'd81);
        e = '{data: 32'd9, tag: 6'd9, dz: 1'b0};
        sb.push_back(e);
        @(posedge clk); #1;
        cdb_grant   = 1'b0;
        issue_valid = 1'b0;
        @(negedge clk); #1;
        check("t3_req_dropped", 64'(cdb_req), 64'd0);
        check("t3_busy", 64'(busy), 64'd1);
        wait_req(60, lat);
        check("t3_latency2", 64'(lat), 64'(LAT));
        grant_one();

        // 4: flush when cnt==10 (cycle 22 after accept)
        @(negedge clk);
        drive_issue(32'd77, 32'd7, 6'd11);
        @(posedge clk); #1;
        issue_valid = 1'b0;
        repeat (21) @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        drive_issue(32'd4, 32'd2, 6'd12);
        #1;
        check("t4_flush_ready", 64'(issue_ready), 64'd0);
        check("t4_flush_enable", 64'(div_enable), 64'd0);
        @(posedge clk); #1;
        flush       = 1'b0;
        issue_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (issue_ready || cdb_req || !busy) seen = 1'b1;
        end
        check("t4_drain_blocked", 64'(seen), 64'd0);
        @(negedge clk); #1;
        check("t4_idle_ready", 64'(issue_ready), 64'd1);
        check("t4_idle_busy", 64'(busy), 64'd0);
        check("t4_no_req", 64'(cdb_req), 64'd0);

        // 5: flush and grant together in DONE; the same-cycle issue is rejected
        @(negedge clk);
        drive_issue(32'd60, 32'd4, 6'd20);
        e = '{data: 32'd15, tag: 6'd20, dz: 1'b0};
        sb.push_back(e);
        @(posedge clk); #1;
        issue_valid = 1'b0;
        wait_req(60, lat);
        check("t5_latency", 64'(lat), 64'(LAT + 1));
        @(negedge clk);
        flush     = 1'b1;
        cdb_grant = 1'b1;
        drive_issue(32'd30, 32'd3, 6'd21);
        #1;
        check("t5_ready", 64'(issue_ready), 64'd0);
        check("t5_enable", 64'(div_enable), 64'd0);
        @(posedge clk); #1;
        flush       = 1'b0;
        cdb_grant   = 1'b0;
        issue_valid = 1'b0;
        @(negedge clk); #1;
        check("t5_req", 64'(cdb_req), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_ready_next", 64'(issue_ready), 64'd1);

        // 6: async reset while waiting on the divider
        @(negedge clk);
        drive_issue(32'd200, 32'd10, 6'd30);
        @(posedge clk); #1;
        issue_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_ready", 64'(issue_ready), 64'd0);
        check("t6_req", 64'(cdb_req), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < LAT + 8; i++) begin
            @(negedge clk); #1;
            if (cdb_req || busy) seen = 1'b1;
        end
        check("t6_late_result_ignored", 64'(seen), 64'd0);

        repeat (2) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
